// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the five-stage pipeline: per-latch flush/freeze, PC enable,
// halt tracking and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dmem_req,
    input  logic             dhit,
    input  logic             dx_memread,
    input  logic [REG_W-1:0] dx_rd,
    input  logic [REG_W-1:0] fd_rs,
    input  logic [REG_W-1:0] fd_rt,
    input  logic             branch_taken_ex,
    input  logic             jump_id,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             fd_flush,
    output logic             fd_freeze,
    output logic             dx_flush,
    output logic             dx_freeze,
    output logic             xm_flush,
    output logic             xm_freeze,
    output logic             mw_flush,
    output logic             mw_freeze,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               dstall, lu;
    logic               stall_evt, flush_evt;

    assign dstall = dmem_req & ~dhit;
    assign lu     = dx_memread & (dx_rd != '0) & ((dx_rd == fd_rs) | (dx_rd == fd_rt));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN: begin
                if (dstall)        state_d = S_DWAIT;
                else if (halt_mem) state_d = S_HALTED;
            end
            S_DWAIT: begin
                if (dhit) state_d = S_RUN;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_RUN;
        endcase
    end

    // Redirects drive pc_en from ihit so the PC never skips past an incomplete fetch.
    always_comb begin
        pc_en     = 1'b0;
        fd_flush  = 1'b0;
        fd_freeze = 1'b0;
        dx_flush  = 1'b0;
        dx_freeze = 1'b0;
        xm_flush  = 1'b0;
        xm_freeze = 1'b0;
        mw_flush  = 1'b0;
        mw_freeze = 1'b0;
        stall_evt = 1'b0;
        flush_evt = 1'b0;
        if (RST) begin
            {fd_flush, dx_flush, xm_flush, mw_flush}     = 4'hf;
            {fd_freeze, dx_freeze, xm_freeze, mw_freeze} = 4'hf;
        end else if (state_q == S_HALTED) begin
            {fd_freeze, dx_freeze, xm_freeze, mw_freeze} = 4'hf;
        end else begin
            if (dstall) begin
                {fd_freeze, dx_freeze, xm_freeze, mw_freeze} = 4'hf;
            end else if (branch_taken_ex) begin
                fd_flush  = 1'b1;
                dx_flush  = 1'b1;
                pc_en     = ihit;
                flush_evt = 1'b1;
            end else if (lu) begin
                fd_freeze = 1'b1;
                dx_flush  = 1'b1;
            end else if (jump_id) begin
                fd_flush  = 1'b1;
                pc_en     = ihit;
                flush_evt = 1'b1;
            end else if (!ihit) begin
                fd_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
            stall_evt = ~pc_en;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    assign halt        = (state_q == S_HALTED);
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; narrow counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int REG_W = 5;

    // Control vector order: {pc_en, fd_flush, fd_freeze, dx_flush, dx_freeze,
    //                        xm_flush, xm_freeze, mw_flush, mw_freeze}
    localparam logic [8:0] C_NORMAL  = 9'h100;
    localparam logic [8:0] C_RESET   = 9'h0ff;
    localparam logic [8:0] C_FREEZE  = 9'h055;
    localparam logic [8:0] C_BRANCH  = 9'h1a0;
    localparam logic [8:0] C_BR_NOI  = 9'h0a0;
    localparam logic [8:0] C_LU      = 9'h060;
    localparam logic [8:0] C_JUMP    = 9'h180;
    localparam logic [8:0] C_NOFETCH = 9'h080;

    localparam logic [1:0] S_RUN = 2'd0, S_DWAIT = 2'd1, S_HALTED = 2'd2;

    logic CLK = 1'b0;
    logic RST;
    logic ihit, dmem_req, dhit, dx_memread, branch_taken_ex, jump_id, halt_mem;
    logic [REG_W-1:0] dx_rd, fd_rs, fd_rt;
    logic pc_en, fd_flush, fd_freeze, dx_flush, dx_freeze;
    logic xm_flush, xm_freeze, mw_flush, mw_freeze, halt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] dbg_state;
    logic [8:0] ctrl;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
        .dx_memread(dx_memread), .dx_rd(dx_rd), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .halt_mem(halt_mem),
        .pc_en(pc_en), .fd_flush(fd_flush), .fd_freeze(fd_freeze),
        .dx_flush(dx_flush), .dx_freeze(dx_freeze), .xm_flush(xm_flush),
        .xm_freeze(xm_freeze), .mw_flush(mw_flush), .mw_freeze(mw_freeze),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_state_o(dbg_state)
    );

    assign ctrl = {pc_en, fd_flush, fd_freeze, dx_flush, dx_freeze,
                   xm_flush, xm_freeze, mw_flush, mw_freeze};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dmem_req = 1'b0; dhit = 1'b0; dx_memread = 1'b0;
        branch_taken_ex = 1'b0; jump_id = 1'b0; halt_mem = 1'b0;
        dx_rd = '0; fd_rs = '0; fd_rt = '0;
    endtask

    // Inputs are already applied at posedge+1; check comb outputs mid-cycle, then clock.
    task automatic cyc(input string tag, input logic [8:0] exp_ctrl);
        #3;
        check(tag, {23'd0, ctrl}, {23'd0, exp_ctrl});
        @(posedge CLK);
        #1;
    endtask

    task automatic regs(input string tag, input logic [1:0] st, input logic h,
                        input int sc, input int fc);
        check({tag, ".state"}, {30'd0, dbg_state}, {30'd0, st});
        check({tag, ".halt"}, {31'd0, halt}, {31'd0, h});
        check({tag, ".stall_cnt"}, {28'd0, stall_cnt}, sc);
        check({tag, ".flush_cnt"}, {28'd0, flush_cnt}, fc);
    endtask

    initial begin
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ctrl", {23'd0, ctrl}, {23'd0, C_RESET});
        regs("rst", S_RUN, 1'b0, 0, 0);
        RST = 1'b0;

        cyc("idle", C_NORMAL);
        regs("idle", S_RUN, 1'b0, 0, 0);

        dx_memread = 1'b1; dx_rd = 5'd4; fd_rs = 5'd4;
        cyc("lu_rs", C_LU);
        regs("lu_rs", S_RUN, 1'b0, 1, 0);
        dx_rd = 5'd0; fd_rs = 5'd0;
        cyc("lu_r0", C_NORMAL);
        dx_rd = 5'd7; fd_rs = 5'd1; fd_rt = 5'd7;
        cyc("lu_rt", C_LU);
        regs("lu", S_RUN, 1'b0, 2, 0);
        idle();

        dmem_req = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc("dstall", C_FREEZE);
            check("dstall.state", {30'd0, dbg_state}, {30'd0, S_DWAIT});
        end
        regs("dstall", S_DWAIT, 1'b0, 5, 0);
        dhit = 1'b1;
        cyc("dhit", C_NORMAL);
        regs("dhit", S_RUN, 1'b0, 5, 0);

        dhit = 1'b0; branch_taken_ex = 1'b1;
        cyc("br_stall0", C_FREEZE);
        cyc("br_stall1", C_FREEZE);
        regs("br_stall", S_DWAIT, 1'b0, 7, 0);
        dhit = 1'b1;
        cyc("br_dhit", C_BRANCH);
        regs("br_dhit", S_RUN, 1'b0, 7, 1);
        idle();

        branch_taken_ex = 1'b1; ihit = 1'b0;
        cyc("br_noihit", C_BR_NOI);
        regs("br_noihit", S_RUN, 1'b0, 8, 2);
        idle();
        jump_id = 1'b1; dx_memread = 1'b1; dx_rd = 5'd3; fd_rs = 5'd3;
        cyc("jump_lu", C_LU);
        regs("jump_lu", S_RUN, 1'b0, 9, 2);
        idle();
        jump_id = 1'b1;
        cyc("jump", C_JUMP);
        idle();
        ihit = 1'b0;
        cyc("nofetch", C_NOFETCH);
        idle();
        branch_taken_ex = 1'b1; dx_memread = 1'b1; dx_rd = 5'd3; fd_rt = 5'd3; jump_id = 1'b1;
        cyc("br_over_lu", C_BRANCH);
        regs("mix", S_RUN, 1'b0, 10, 4);
        idle();

        halt_mem = 1'b1; dmem_req = 1'b1; dhit = 1'b0;
        cyc("halt_dstall", C_FREEZE);
        regs("halt_dstall", S_DWAIT, 1'b0, 11, 4);
        dhit = 1'b1;
        cyc("halt_dwait", C_NORMAL);
        regs("halt_dwait", S_RUN, 1'b0, 11, 4);
        dmem_req = 1'b0;
        cyc("halt_go", C_NORMAL);
        regs("halted", S_HALTED, 1'b1, 11, 4);
        idle();
        ihit = 1'b0; branch_taken_ex = 1'b1; dmem_req = 1'b1; dhit = 1'b1;
        cyc("halted0", C_FREEZE);
        dhit = 1'b0; jump_id = 1'b1; halt_mem = 1'b0;
        cyc("halted1", C_FREEZE);
        regs("halted_hold", S_HALTED, 1'b1, 11, 4);
        idle();

        RST = 1'b1;
        #3;
        check("rst_pulse_ctrl", {23'd0, ctrl}, {23'd0, C_RESET});
        regs("rst_pulse", S_RUN, 1'b0, 0, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc("post_rst", C_NORMAL);
        regs("post_rst", S_RUN, 1'b0, 0, 0);

        ihit = 1'b0;
        for (int i = 0; i < 17; i++) cyc("sat_stall", C_NOFETCH);
        regs("sat_stall", S_RUN, 1'b0, 15, 0);
        idle();
        jump_id = 1'b1;
        for (int i = 0; i < 17; i++) cyc("sat_flush", C_JUMP);
        regs("sat_flush", S_RUN, 1'b0, 15, 15);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
